// File: rtl/mips_pkg.sv
// Shared types and sizes for the multiply unit.
package mips_pkg;
    typedef enum logic [1:0] {IDLE, CALC, COMMIT} mult_state_t;
    localparam int MULT_W     = 32;
    localparam int MULT_CNT_W = $clog2(MULT_W) + 1;
endpackage

// File: rtl/mult_negate.sv
// Conditional two's complement: y = neg ? -a : a.
module mult_negate #(
    parameter int N = 32
) (
    input  logic         neg,
    input  logic [N-1:0] a,
    output logic [N-1:0] y
);
    assign y = neg ? (~a + N'(1)) : a;
endmodule

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier holding the architectural HI/LO pair.
// Optional MULT_EARLY_TERM_EN: leave CALC once the remaining multiplier bits are zero.
import mips_pkg::*;

module mult_unit #(
    parameter int WIDTH = MULT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic             flush,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
`ifdef MULT_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    mult_state_t             state;
    logic [MULT_CNT_W-1:0]   count;
    logic [WIDTH-1:0]        absA, absB, mplier;
    logic [2*WIDTH-1:0]      mcand, acc, result;
    logic                    neg, lastIter;

    mult_negate #(.N(WIDTH))   negA (.neg(sgn & srca[WIDTH-1]), .a(srca), .y(absA));
    mult_negate #(.N(WIDTH))   negB (.neg(sgn & srcb[WIDTH-1]), .a(srcb), .y(absB));
    mult_negate #(.N(2*WIDTH)) negR (.neg(neg), .a(acc), .y(result));

    // The multiplicand is kept pre-shifted in a 2W register, so mcand == |srca| << count.
    assign lastIter = (count == MULT_CNT_W'(WIDTH - 1)) ||
                      (EARLY_TERM && (mplier[WIDTH-1:1] == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        mcand  <= {{WIDTH{1'b0}}, absA};
                        mplier <= absB;
                        neg    <= sgn & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (mplier[0])
                            acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + MULT_CNT_W'(1);
                        if (lastIter)
                            state <= COMMIT;
                    end
                end
                COMMIT: begin
                    // A squash here must leave HI/LO untouched.
                    if (!flush) begin
                        {hi, lo} <= result;
                        done     <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: cycle-level behavioural model plus directed literal cases.
module tb_mult_unit;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sgn = 1'b0, flush = 1'b0;
    logic [31:0] srca = '0, srcb = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          checks = 0, errors = 0;
    bit          checkEn = 1'b0;

    always #5 clk = ~clk;

    mult_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn), .flush(flush),
        .srca(srca), .srcb(srcb), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        ua = a;
        ub = b;
        return ua * ub;
    endfunction

    // Cycles from the start edge to the edge that writes HI/LO.
    function automatic int lat(input logic [31:0] b, input logic s);
`ifdef MULT_EARLY_TERM_EN
        logic [31:0] mag;
        int hb;
        mag = (s && b[31]) ? (~b + 32'd1) : b;
        hb = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) hb = i;
        return hb + 2;
`else
        return 33;
`endif
    endfunction

    // Behavioural model: an in-flight op is just a product and a countdown.
    bit          mBusy, mDone;
    logic [31:0] mHi, mLo;
    logic [63:0] mProd;
    int          mLeft;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mBusy <= 1'b0; mDone <= 1'b0; mHi <= '0; mLo <= '0; mLeft <= 0; mProd <= '0;
        end else if (mBusy) begin
            if (flush) begin
                mBusy <= 1'b0; mDone <= 1'b0;
            end else if (mLeft == 1) begin
                mHi <= mProd[63:32]; mLo <= mProd[31:0]; mDone <= 1'b1; mBusy <= 1'b0;
            end else begin
                mLeft <= mLeft - 1; mDone <= 1'b0;
            end
        end else begin
            mDone <= 1'b0;
            if (start && !flush) begin
                mProd <= prod(srca, srcb, sgn);
                mLeft <= lat(srcb, sgn);
                mBusy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            chk("busy", 64'(busy), 64'(mBusy));
            chk("done", 64'(done), 64'(mDone));
            chk("hi",   64'(hi),   64'(mHi));
            chk("lo",   64'(lo),   64'(mLo));
        end
    end

    // Issue one op and wait (bounded) for done; returns observed latency and busy-cycle count.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int k, output int busyCnt);
        @(negedge clk);
        srca = a; srcb = b; sgn = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; busyCnt = 0;
        while (!done && k < 60) begin
            if (busy) busyCnt++;
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 64'(k), 64'(0));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 15));
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k, bc;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        checkEn = 1'b1;

        // 1: unsigned all-ones squared
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, k, bc);
        chk("t1_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("t1_lo", 64'(lo), 64'h0000_0001);
        chk("t1_latency", 64'(k), 64'd33);
        chk("t1_busy_cycles", 64'(bc), 64'd33);

        // 2: -3 x 5 signed and unsigned
        runOp(32'hFFFF_FFFD, 32'd5, 1'b1, k, bc);
        chk("t2s_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("t2s_lo", 64'(lo), 64'hFFFF_FFF1);
        chk("t2s_latency", 64'(k), 64'(lat(32'd5, 1'b1)));
        runOp(32'hFFFF_FFFD, 32'd5, 1'b0, k, bc);
        chk("t2u_hi", 64'(hi), 64'h0000_0004);
        chk("t2u_lo", 64'(lo), 64'hFFFF_FFF1);

        // 3: most-negative operand
        runOp(32'h8000_0000, 32'h8000_0000, 1'b1, k, bc);
        chk("t3a_hi", 64'(hi), 64'h4000_0000);
        chk("t3a_lo", 64'(lo), 64'h0000_0000);
        runOp(32'h8000_0000, 32'd1, 1'b1, k, bc);
        chk("t3b_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("t3b_lo", 64'(lo), 64'h8000_0000);

        // 4: ignored restart then flush
        runOp(32'd6, 32'd7, 1'b0, k, bc);
        chk("t4_lo42", 64'(lo), 64'd42);
        @(negedge clk);
        srca = 32'd2; srcb = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        srca = 32'd9; srcb = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t4_busy_after_flush", 64'(busy), 64'd0);
        chk("t4_no_done", 64'(done), 64'd0);
        repeat (40) @(negedge clk);
        chk("t4_hi_kept", 64'(hi), 64'd0);
        chk("t4_lo_kept", 64'(lo), 64'd42);

        // 5: reset mid-operation, then resume
        runOp(32'd6, 32'd7, 1'b0, k, bc);
        @(negedge clk);
        srca = 32'h0001_0000; srcb = 32'h0001_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_hi",   64'(hi),   64'd0);
        chk("t5_rst_lo",   64'(lo),   64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        runOp(32'd2, 32'd3, 1'b0, k, bc);
        chk("t5_lo6", 64'(lo), 64'd6);

        // 6: short multiplier
        runOp(32'd7, 32'd1, 1'b0, k, bc);
        chk("t6_lo", 64'(lo), 64'd7);
`ifdef MULT_EARLY_TERM_EN
        chk("t6_latency", 64'(k), 64'd2);
`else
        chk("t6_latency", 64'(k), 64'd33);
`endif

        // Random traffic: starts while busy, back-to-back with done, flushes
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = ($urandom % 3) == 0;
            flush = ($urandom % 80) == 0;
            sgn   = 1'($urandom);
            srca  = pick();
            srcb  = pick();
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
